// File: rtl/combi_pkg.sv
// Shared constants and types for the combi self-test controller.
package combi_pkg;
  localparam int NVEC  = 16;
  localparam int VEC_W = 4;

  localparam logic [NVEC-1:0] EXP_X_DEF = 16'h6996;
  localparam logic [NVEC-1:0] EXP_Y_DEF = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/combi_expect.sv
// Golden response table: vector index -> expected {x,y}.
module combi_expect
  import combi_pkg::*;
#(
  parameter logic [NVEC-1:0] EXP_X = EXP_X_DEF,
  parameter logic [NVEC-1:0] EXP_Y = EXP_Y_DEF
) (
  input  logic [VEC_W-1:0] vec,
  output logic             exp_x,
  output logic             exp_y
);
  assign exp_x = EXP_X[vec];
  assign exp_y = EXP_Y[vec];
endmodule

// File: rtl/combi_checker.sv
// Self-test controller: walks all 16 input vectors of combi, holds each for
// HOLD_CYCLES, samples x/y on the last hold edge and scores the responses.
module combi_checker
  import combi_pkg::*;
#(
  parameter int              HOLD_CYCLES = 4,
  parameter logic [NVEC-1:0] EXP_X       = EXP_X_DEF,
  parameter logic [NVEC-1:0] EXP_Y       = EXP_Y_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [VEC_W-1:0] abcd,
  input  logic             x_in,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);
  localparam logic [3:0]       HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST  = VEC_W'(NVEC - 1);

  state_t           state, state_n;
  logic [VEC_W-1:0] vec, vec_n;
  logic [3:0]       hold_cnt, hold_n;
  logic [VEC_W-1:0] abcd_n, fail_vec_n;
  logic             busy_n, done_n, pass_n, fail_valid_n;
  logic [4:0]       err_n;
  logic             exp_x, exp_y, mismatch;

  combi_expect #(.EXP_X(EXP_X), .EXP_Y(EXP_Y)) u_expect (
    .vec   (vec),
    .exp_x (exp_x),
    .exp_y (exp_y)
  );

  // x and y failing on the same vector still counts as one error
  assign mismatch = (x_in != exp_x) || (y_in != exp_y);

  always_comb begin
    state_n      = state;
    vec_n        = vec;
    hold_n       = hold_cnt;
    abcd_n       = abcd;
    busy_n       = busy;
    done_n       = done;
    pass_n       = pass;
    err_n        = err_count;
    fail_valid_n = fail_valid;
    fail_vec_n   = fail_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = APPLY;
          vec_n        = '0;
          hold_n       = '0;
          abcd_n       = '0;
          busy_n       = 1'b1;
          done_n       = 1'b0;
          pass_n       = 1'b0;
          err_n        = '0;
          fail_valid_n = 1'b0;
          fail_vec_n   = '0;
        end
      end
      APPLY: begin
        if (hold_cnt == HOLD_LAST) begin
          if (mismatch) begin
            err_n = err_count + 5'd1;
            if (!fail_valid) begin
              fail_valid_n = 1'b1;
              fail_vec_n   = vec;
            end
          end
          if (vec == VEC_LAST) begin
            // abcd stays on the last vector while DONE
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == 5'd0);
          end else begin
            vec_n  = vec + 4'd1;
            abcd_n = vec + 4'd1;
            hold_n = '0;
          end
        end else begin
          hold_n = hold_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      hold_cnt   <= '0;
      abcd       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      hold_cnt   <= hold_n;
      abcd       <= abcd_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_count  <= err_n;
      fail_valid <= fail_valid_n;
      fail_vec   <= fail_vec_n;
    end
  end
endmodule

// File: tb/tb_combi_checker.sv
// Directed bench for combi_checker: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances
// driven by a behavioural combi model with selectable faults.
module tb_combi_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, start1 = 1'b0;
  logic [3:0] abcd, abcd1;
  logic       x_in, y_in, x1, y1;
  logic       busy, done, pass, fail_valid;
  logic       busy1, done1, pass1, fail_valid1;
  logic [4:0] err_count, err_count1;
  logic [3:0] fail_vec, fail_vec1;
  int         fault = 0;  // 0 golden, 1 y stuck-at-0, 2 x inverted
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign x_in = (^abcd) ^ (fault == 2);
  assign y_in = (&abcd) & (fault != 1);
  assign x1   = ^abcd1;
  assign y1   = &abcd1;

  combi_checker #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abcd(abcd), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  combi_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abcd(abcd1), .x_in(x1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_valid(fail_valid1), .fail_vec(fail_vec1)
  );

  // Stimulus only: pulses start on dut and records done latency, abcd sequence
  // deviations and busy/done overlap. edges=-1 means done never came.
  task automatic run4(input bit pulse_mid, output int edges, output int seq_bad,
                      output int overlap);
    logic [3:0] exp_abcd;
    edges = -1; seq_bad = 0; overlap = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (abcd !== 4'd0 || busy !== 1'b1 || done !== 1'b0) seq_bad++;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      exp_abcd = (k >= 64) ? 4'hF : 4'(k / 4);
      if (abcd !== exp_abcd) seq_bad++;
      if (busy === 1'b1 && done === 1'b1) overlap++;
      if (pulse_mid) start = (k == 10);
      if (done === 1'b1) begin
        edges = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({abcd, busy, done, pass, err_count, fail_valid, fail_vec} !== 17'd0) begin
      errors++;
      $display("FAIL reset_dut4: outputs=%h required 0",
               {abcd, busy, done, pass, err_count, fail_valid, fail_vec});
    end
    checks++;
    if ({abcd1, busy1, done1, pass1, err_count1, fail_valid1, fail_vec1} !== 17'd0) begin
      errors++;
      $display("FAIL reset_dut1: outputs=%h required 0",
               {abcd1, busy1, done1, pass1, err_count1, fail_valid1, fail_vec1});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_golden;
    int edges, seq_bad, overlap;
    fault = 0;
    run4(1'b0, edges, seq_bad, overlap);
    checks++;
    if (edges !== 64) begin errors++; $display("FAIL golden_latency: got %0d required 64", edges); end
    checks++;
    if (seq_bad !== 0) begin errors++; $display("FAIL golden_abcd_seq: %0d bad cycles required 0", seq_bad); end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL golden_overlap: %0d cycles required 0", overlap); end
    checks++;
    if (pass !== 1'b1 || err_count !== 5'd0 || fail_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL golden_result: pass=%b err=%0d fv=%b busy=%b required 1 0 0 0",
               pass, err_count, fail_valid, busy);
    end
  endtask

  task automatic test_y_stuck;
    int edges, seq_bad, overlap;
    fault = 1;
    run4(1'b0, edges, seq_bad, overlap);
    checks++;
    if (edges !== 64) begin errors++; $display("FAIL ystuck_latency: got %0d required 64", edges); end
    checks++;
    if (err_count !== 5'd1 || fail_vec !== 4'd15 || fail_valid !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL ystuck_result: err=%0d fvec=%0d fv=%b pass=%b required 1 15 1 0",
               err_count, fail_vec, fail_valid, pass);
    end
  endtask

  task automatic test_x_invert;
    int edges, seq_bad, overlap;
    fault = 2;
    run4(1'b0, edges, seq_bad, overlap);
    checks++;
    if (err_count !== 5'd16 || fail_vec !== 4'd0 || fail_valid !== 1'b1 || pass !== 1'b0
        || edges !== 64) begin
      errors++;
      $display("FAIL xinv_result: err=%0d fvec=%0d fv=%b pass=%b edges=%0d required 16 0 1 0 64",
               err_count, fail_vec, fail_valid, pass, edges);
    end
  endtask

  // DUT is left in DONE with err_count=16 from test_x_invert
  task automatic test_restart_from_done;
    int edges, seq_bad, overlap;
    fault = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err_count !== 5'd0 || fail_valid !== 1'b0
        || fail_vec !== 4'd0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: busy=%b done=%b err=%0d fv=%b fvec=%0d pass=%b required 1 0 0 0 0 0",
               busy, done, err_count, fail_valid, fail_vec, pass);
    end
    edges = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin edges = k; break; end
    end
    checks++;
    if (edges !== 64 || pass !== 1'b1) begin
      errors++;
      $display("FAIL restart_run: edges=%0d pass=%b required 64 1", edges, pass);
    end
    run4(1'b1, edges, seq_bad, overlap);
    checks++;
    if (edges !== 64 || seq_bad !== 0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL start_in_apply: edges=%0d seq_bad=%0d pass=%b required 64 0 1",
               edges, seq_bad, pass);
    end
  endtask

  task automatic test_reset_mid_run;
    int edges, seq_bad, overlap, found;
    fault = 0;
    found = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (abcd === 4'd7) begin found = 1; break; end
    end
    checks++;
    if (found !== 1) begin errors++; $display("FAIL midrun_reach7: found=%0d required 1", found); end
    #2 rst_n = 1'b0;
    #1 checks++;
    if ({abcd, busy, done, pass, err_count, fail_valid, fail_vec} !== 17'd0) begin
      errors++;
      $display("FAIL midrun_reset: outputs=%h required 0",
               {abcd, busy, done, pass, err_count, fail_valid, fail_vec});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run4(1'b0, edges, seq_bad, overlap);
    checks++;
    if (edges !== 64 || pass !== 1'b1 || err_count !== 5'd0) begin
      errors++;
      $display("FAIL midrun_rerun: edges=%0d pass=%b err=%0d required 64 1 0", edges, pass, err_count);
    end
  endtask

  task automatic test_back_to_back;
    int found, done_cycles;
    fault = 0;
    found = 0;
    done_cycles = 0;
    @(posedge clk); #1 start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin found = 1; break; end
    end
    if (found == 1) done_cycles = 1;
    @(posedge clk); #1;
    if (done === 1'b1) done_cycles++;
    checks++;
    if (found !== 1 || done_cycles !== 1 || busy !== 1'b1 || abcd !== 4'd0) begin
      errors++;
      $display("FAIL back_to_back: found=%0d done_cycles=%0d busy=%b abcd=%0d required 1 1 1 0",
               found, done_cycles, busy, abcd);
    end
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) break;
    end
  endtask

  task automatic test_hold1;
    int edges, seq_bad;
    logic [3:0] exp_abcd;
    edges = -1; seq_bad = 0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    if (abcd1 !== 4'd0 || busy1 !== 1'b1) seq_bad++;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      exp_abcd = (k >= 16) ? 4'hF : 4'(k);
      if (abcd1 !== exp_abcd) seq_bad++;
      if (done1 === 1'b1) begin edges = k; break; end
    end
    checks++;
    if (edges !== 16) begin errors++; $display("FAIL hold1_latency: got %0d required 16", edges); end
    checks++;
    if (seq_bad !== 0 || pass1 !== 1'b1 || err_count1 !== 5'd0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL hold1_result: seq_bad=%0d pass=%b err=%0d busy=%b required 0 1 0 0",
               seq_bad, pass1, err_count1, busy1);
    end
  endtask

  initial begin
    test_reset;
    test_golden;
    test_y_stuck;
    test_x_invert;
    test_restart_from_done;
    test_reset_mid_run;
    test_back_to_back;
    test_hold1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
